ola_trigger_match: RTL and testbench

OLA_TRIGGER_MATCH -- requirements
Module: ola_trigger_match

---
 rtl/ola_trigger_match_if.sv | 11 +
 rtl/ola_trigger_match.sv | 116 +++++++++++
 tb/tb_ola_trigger_match.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ola_trigger_match_if.sv
// rtl/ola_trigger_match_if.sv - configuration write bus for the trigger matcher
interface ola_trigger_match_if #(
  parameter int cw = 16
);
  logic          cfg_write;
  logic [1:0]    cfg_addr;
  logic [cw-1:0] cfg_data;

  modport master (output cfg_write, output cfg_addr, output cfg_data);
  modport slave  (input  cfg_write, input  cfg_addr, input  cfg_data);
endinterface

// File: rtl/ola_trigger_match.sv
// rtl/ola_trigger_match.sv - mask/value trigger with match count and post-match delay
module ola_trigger_match #(
  parameter int width = 8,
  parameter int cw    = 16
) (
  input  logic                 reset,
  input  logic                 clock,
  ola_trigger_match_if.slave   cfg,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic                 in_valid,
  input  logic [width-1:0]     in_sample,
  output logic                 out_valid,
  output logic [width-1:0]     out_sample,
  output logic                 armed,
  output logic                 trig,
  output logic                 fired
);

  typedef enum logic [1:0] {IDLE, ARMED, DELAY, FIRED} state_t;

  localparam logic [cw-1:0] ONE = cw'(1);

  state_t           state;
  logic [width-1:0] mask;
  logic [width-1:0] value;
  logic [cw-1:0]    count;
  logic [cw-1:0]    delay;
  logic [cw-1:0]    mcnt;
  logic [cw-1:0]    dcnt;
  logic             match;

  assign match = in_valid && (((in_sample ^ value) & mask) == '0);

  // Outputs are registered alongside the state so trig lines up with the
  // delayed copy of the sample that caused the transition.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mask       <= '0;
      value      <= '0;
      count      <= '0;
      delay      <= '0;
      mcnt       <= '0;
      dcnt       <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      armed      <= 1'b0;
      trig       <= 1'b0;
      fired      <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      out_sample <= in_sample;
      trig       <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_write) begin
            case (cfg.cfg_addr)
              2'd0: mask  <= cfg.cfg_data[width-1:0];
              2'd1: value <= cfg.cfg_data[width-1:0];
              2'd2: count <= cfg.cfg_data;
              2'd3: delay <= cfg.cfg_data;
            endcase
          end
          if (arm && !disarm) begin
            state <= ARMED;
            armed <= 1'b1;
            mcnt  <= count;
            dcnt  <= delay;
          end
        end
        ARMED: begin
          if (disarm) begin
            state <= IDLE;
            armed <= 1'b0;
          end else if (match) begin
            // count of 0 falls into the same branch as 1
            if (mcnt <= ONE) begin
              if (delay != '0) begin
                state <= DELAY;
              end else begin
                state <= FIRED;
                armed <= 1'b0;
                fired <= 1'b1;
                trig  <= 1'b1;
              end
            end
            if (mcnt != '0) mcnt <= mcnt - ONE;
          end
        end
        DELAY: begin
          if (disarm) begin
            state <= IDLE;
            armed <= 1'b0;
          end else if (in_valid) begin
            if (dcnt <= ONE) begin
              state <= FIRED;
              armed <= 1'b0;
              fired <= 1'b1;
              trig  <= 1'b1;
            end
            if (dcnt != '0) dcnt <= dcnt - ONE;
          end
        end
        FIRED: begin
          if (disarm) begin
            state <= IDLE;
            fired <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ola_trigger_match.sv
// tb/tb_ola_trigger_match.sv - directed self-checking bench for ola_trigger_match
module tb_ola_trigger_match;
  logic       reset;
  logic       clock;
  logic       arm;
  logic       disarm;
  logic       in_valid;
  logic [7:0] in_sample;
  logic       out_valid;
  logic [7:0] out_sample;
  logic       armed;
  logic       trig;
  logic       fired;
  int         n_checks;
  int         n_pass;

  ola_trigger_match_if #(.cw(16)) cfg_bus ();

  ola_trigger_match #(.width(8), .cw(16)) dut (
    .reset      (reset),
    .clock      (clock),
    .cfg        (cfg_bus),
    .arm        (arm),
    .disarm     (disarm),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .armed      (armed),
    .trig       (trig),
    .fired      (fired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input logic v, input logic [7:0] s, input logic a, input logic d);
    in_valid  = v;
    in_sample = s;
    arm       = a;
    disarm    = d;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    arm      = 1'b0;
    disarm   = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    cfg_bus.cfg_write = 1'b1;
    cfg_bus.cfg_addr  = addr;
    cfg_bus.cfg_data  = data;
    @(posedge clock);
    #1;
    cfg_bus.cfg_write = 1'b0;
  endtask

  task automatic setup(input logic [7:0] m, input logic [7:0] v, input logic [15:0] c, input logic [15:0] d);
    wr(2'd0, {8'h00, m});
    wr(2'd1, {8'h00, v});
    wr(2'd2, c);
    wr(2'd3, d);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_armed"}, armed, 0);
    check({tag, "_trig"}, trig, 0);
    check({tag, "_fired"}, fired, 0);
    check({tag, "_oval"}, out_valid, 0);
    check({tag, "_osmp"}, out_sample, 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    arm = 1'b0; disarm = 1'b0; in_valid = 1'b0; in_sample = 8'h00;
    cfg_bus.cfg_write = 1'b0; cfg_bus.cfg_addr = 2'd0; cfg_bus.cfg_data = 16'h0;
    #12;
    check_idle_outputs("rst");
    reset = 1'b0;
    @(posedge clock); #1;

    // exact match, count 1, no delay
    setup(8'hFF, 8'h5A, 16'd1, 16'd0);
    cyc(0, 8'h00, 1, 0);
    check("t1_armed", armed, 1);
    cyc(1, 8'h00, 0, 0);
    check("t1_notrig", trig, 0);
    check("t1_oval0", out_valid, 1);
    cyc(1, 8'h5A, 0, 0);
    check("t1_trig", trig, 1);
    check("t1_osmp", out_sample, 8'h5A);
    check("t1_fired", fired, 1);
    check("t1_unarm", armed, 0);
    cyc(0, 8'h00, 0, 0);
    check("t1_trig_once", trig, 0);
    check("t1_hold", fired, 1);
    cyc(0, 8'h00, 1, 0);
    check("t1_arm_ign", fired, 1);
    cyc(0, 8'h00, 0, 1);
    check("t1_dis_fired", fired, 0);
    check("t1_dis_armed", armed, 0);

    // nibble mask, count 3
    setup(8'hF0, 8'h30, 16'd3, 16'd0);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h31, 0, 0);
    check("t2_s31", trig, 0);
    cyc(1, 8'h00, 0, 0);
    check("t2_s00", trig, 0);
    cyc(1, 8'h3F, 0, 0);
    check("t2_s3f", trig, 0);
    cyc(1, 8'h35, 0, 0);
    check("t2_trig", trig, 1);
    check("t2_osmp", out_sample, 8'h35);
    cyc(0, 8'h00, 0, 1);

    // count 1, delay 2, invalid gap
    setup(8'hFF, 8'h77, 16'd1, 16'd2);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h77, 0, 0);
    check("t3_m_trig", trig, 0);
    check("t3_m_armed", armed, 1);
    cyc(1, 8'h01, 0, 0);
    check("t3_d1_trig", trig, 0);
    check("t3_d1_armed", armed, 1);
    cyc(0, 8'h00, 0, 0);
    check("t3_gap_trig", trig, 0);
    check("t3_gap_oval", out_valid, 0);
    cyc(1, 8'h02, 0, 0);
    check("t3_trig", trig, 1);
    check("t3_osmp", out_sample, 8'h02);
    check("t3_fired", fired, 1);
    cyc(0, 8'h00, 0, 1);

    // disarm wins over match; write while armed ignored
    setup(8'hFF, 8'h5A, 16'd1, 16'd0);
    cyc(0, 8'h00, 1, 0);
    wr(2'd1, 16'h0011);
    check("t4_still_armed", armed, 1);
    cyc(1, 8'h5A, 0, 1);
    check("t4_dis_trig", trig, 0);
    check("t4_dis_armed", armed, 0);
    cyc(0, 8'h00, 0, 0);
    check("t4_after_trig", trig, 0);
    check("t4_after_fired", fired, 0);
    cyc(0, 8'h00, 1, 1);
    check("t4_dis_prio_arm", armed, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h11, 0, 0);
    check("t4_val_kept", trig, 0);
    cyc(1, 8'h5A, 0, 0);
    check("t4_val_trig", trig, 1);
    cyc(0, 8'h00, 0, 1);

    // reset while in DELAY with dcnt=1
    setup(8'hFF, 8'h77, 16'd1, 16'd2);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h77, 0, 0);
    cyc(1, 8'h01, 0, 0);
    in_valid = 1'b1;
    in_sample = 8'h44;
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("t5_async");
    @(posedge clock); #1;
    check_idle_outputs("t5_held");
    in_valid = 1'b0;
    in_sample = 8'h00;
    reset = 1'b0;
    setup(8'hFF, 8'h77, 16'd1, 16'd2);
    cyc(0, 8'h00, 1, 0);
    check("t5_rearm", armed, 1);
    cyc(1, 8'h77, 0, 0);
    check("t5_m_trig", trig, 0);
    cyc(1, 8'h01, 0, 0);
    check("t5_d1_trig", trig, 0);
    cyc(1, 8'h02, 0, 0);
    check("t5_trig", trig, 1);
    check("t5_osmp", out_sample, 8'h02);
    cyc(0, 8'h00, 0, 1);

    // mask 0, count 0
    setup(8'h00, 8'h00, 16'd0, 16'd0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'hC3, 0, 0);
    check("t6_inval_trig", trig, 0);
    cyc(1, 8'hC3, 0, 0);
    check("t6_trig", trig, 1);
    check("t6_osmp", out_sample, 8'hC3);
    cyc(0, 8'h00, 0, 1);
    check("t6_idle", fired, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
